// File: rtl/l1_refill_responder_pkg.sv
// Shared types and constants for the fine-grained multithreaded core's L1 refill path.
package fgmt;

    localparam int WIDTH            = 32;
    localparam int block_size       = 4;
    localparam int TID_bits         = 2;
    localparam int THREAD_POOL_SIZE = 4;
    localparam int BEAT_BITS        = 2;

    typedef struct packed {
        logic [TID_bits-1:0] tid;
        logic [WIDTH-5:0]    line_addr;
    } refill_req_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } refill_state_t;

    // Byte address of one word inside a 16-byte line.
    function automatic logic [WIDTH-1:0] beatAddr(input logic [WIDTH-5:0] lineAddr,
                                                   input logic [BEAT_BITS-1:0] beat);
        return {lineAddr, beat, 2'b00};
    endfunction

endpackage

// File: rtl/l1_refill_responder_if.sv
// Signal bundle joining the refill responder to the L1 request/response port and the backing memory.
interface l1_refill_responder_if;
    import fgmt::*;

    logic                             req_valid;
    logic                             req_ready;
    logic [TID_bits-1:0]              req_tid;
    logic [WIDTH-1:0]                 req_addr;

    logic                             mem_rd_en;
    logic [WIDTH-1:0]                 mem_addr;
    logic                             mem_rd_valid;
    logic [WIDTH-1:0]                 mem_rd_data;

    logic                             resp_valid;
    logic                             resp_ready;
    logic [TID_bits-1:0]              resp_tid;
    logic [WIDTH*block_size-1:0]      resp_line;

    logic [THREAD_POOL_SIZE-1:0]      pending;

    modport slave (
        input  req_valid, req_tid, req_addr, mem_rd_valid, mem_rd_data, resp_ready,
        output req_ready, mem_rd_en, mem_addr, resp_valid, resp_tid, resp_line, pending
    );

    modport master (
        output req_valid, req_tid, req_addr, mem_rd_valid, mem_rd_data, resp_ready,
        input  req_ready, mem_rd_en, mem_addr, resp_valid, resp_tid, resp_line, pending
    );

endinterface

// File: rtl/l1_refill_responder_req_fifo.sv
// In-order queue of accepted refill requests; depth equals the thread count so it cannot overflow.
module refill_req_fifo
    import fgmt::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  refill_req_t i_pushData,
    input  logic        i_pop,
    output refill_req_t o_head,
    output logic        o_empty,
    output logic        o_full
);

    localparam int PTR_W = $clog2(THREAD_POOL_SIZE);
    localparam logic [PTR_W:0] DEPTH = (PTR_W + 1)'(THREAD_POOL_SIZE);

    refill_req_t      r_mem [THREAD_POOL_SIZE];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;
    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == DEPTH);
    assign o_head   = r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

endmodule

// File: rtl/l1_refill_responder.sv
// Serves L1 line refills in arrival order, reading four words per line from a word-wide memory.
module l1_refill_responder
    import fgmt::*;
(
    input logic                  clk,
    input logic                  rst,
    l1_refill_responder_if.slave bus
);

    localparam int WORD_W   = WIDTH;
    localparam int BEATS    = block_size;
    localparam int TID_W    = TID_bits;
    localparam int NTHREADS = THREAD_POOL_SIZE;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

    refill_state_t                r_state;
    refill_state_t                w_stateNext;
    logic [BEAT_BITS-1:0]         r_beat;
    logic [BEAT_BITS-1:0]         w_beatNext;
    logic [BEATS-1:0][WORD_W-1:0] r_line;
    logic [NTHREADS-1:0]          r_pending;

    refill_req_t                  w_pushData;
    refill_req_t                  w_head;
    logic                         w_empty;
    logic                         w_full;
    logic                         w_reqReady;
    logic                         w_accept;
    logic                         w_pop;
    logic                         w_capture;
    logic                         w_memRdEn;
    logic [WORD_W-1:0]            w_memAddr;
    logic                         w_respValid;
    logic [TID_W-1:0]             w_respTid;
    logic                         w_unusedAddrBits;

    // A thread with a refill in flight stays blocked until the cycle after its handshake.
    assign w_reqReady = ~r_pending[bus.req_tid] & ~w_full;
    assign w_accept   = bus.req_valid & w_reqReady;
    assign w_pushData = '{tid: bus.req_tid, line_addr: bus.req_addr[WORD_W-1:4]};
    assign w_unusedAddrBits = &{1'b0, bus.req_addr[3:0]};

    refill_req_fifo u_reqFifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_accept),
        .i_pushData (w_pushData),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

    always_comb begin
        w_stateNext = r_state;
        w_beatNext  = r_beat;
        w_memRdEn   = 1'b0;
        w_memAddr   = '0;
        w_respValid = 1'b0;
        w_respTid   = '0;
        w_capture   = 1'b0;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_stateNext = ISSUE;
                    w_beatNext  = '0;
                end
            end
            ISSUE: begin
                w_memRdEn   = 1'b1;
                w_memAddr   = beatAddr(w_head.line_addr, r_beat);
                w_stateNext = WAIT;
            end
            WAIT: begin
                if (bus.mem_rd_valid) begin
                    w_capture = 1'b1;
                    if (r_beat == LAST_BEAT) begin
                        w_stateNext = RESP;
                    end else begin
                        w_beatNext  = r_beat + 1'b1;
                        w_stateNext = ISSUE;
                    end
                end
            end
            RESP: begin
                w_respValid = 1'b1;
                w_respTid   = w_head.tid;
                if (bus.resp_ready) begin
                    w_pop       = 1'b1;
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Read data is only taken in WAIT, so stray or late memory responses cannot touch the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_line  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_beat  <= w_beatNext;
            if (w_capture) begin
                r_line[r_beat] <= bus.mem_rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            if (w_pop) begin
                r_pending[w_head.tid] <= 1'b0;
            end
            if (w_accept) begin
                r_pending[bus.req_tid] <= 1'b1;
            end
        end
    end

    assign bus.req_ready  = w_reqReady;
    assign bus.mem_rd_en  = w_memRdEn;
    assign bus.mem_addr   = w_memAddr;
    assign bus.resp_valid = w_respValid;
    assign bus.resp_tid   = w_respTid;
    assign bus.resp_line  = r_line;
    assign bus.pending    = r_pending;

endmodule

// File: tb/tb_l1_refill_responder.sv
// Directed and randomized bench for l1_refill_responder with a queue-based reference model and memory model.
module tb_l1_refill_responder;
    import fgmt::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    l1_refill_responder_if bus();

    l1_refill_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0]  tid;
        logic [27:0] lineAddr;
    } expReq_t;

    int          testsRun = 0;
    int          testsFailed = 0;

    int          memLat = 1;
    bit          memLatRandom = 1'b0;
    bit          memDataCounting = 1'b1;
    bit          strayEn = 1'b0;
    int          memCountdown = 0;
    logic [31:0] memPendAddr = '0;
    int          memReads = 0;
    logic [31:0] memAddrLog [$];

    expReq_t     expQ [$];
    bit [3:0]    modelPending = '0;
    bit          lastAccepted;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (memDataCounting) return 32'hA0 + 32'(a[3:2]);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [127:0] expLine(input logic [27:0] lineAddr);
        logic [127:0] line;
        logic [1:0]   k2;
        line = '0;
        for (int k = 0; k < 4; k++) begin
            k2 = 2'(k);
            line[32*k +: 32] = memWord({lineAddr, k2, 2'b00});
        end
        return line;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Word memory: answers each read strobe after memLat cycles; optionally emits stray valid pulses.
    initial begin
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
        forever begin
            @(negedge clk);
            bus.mem_rd_valid = 1'b0;
            if (memCountdown > 0) begin
                memCountdown--;
                if (memCountdown == 0) begin
                    bus.mem_rd_valid = 1'b1;
                    bus.mem_rd_data  = memWord(memPendAddr);
                end
            end else if (strayEn) begin
                bus.mem_rd_valid = 1'b1;
                bus.mem_rd_data  = 32'hDEAD_BEEF;
            end
            if (bus.mem_rd_en === 1'b1) begin
                checkOutput("single_outstanding_read", 128'(memCountdown), 128'(0));
                memPendAddr = bus.mem_addr;
                memAddrLog.push_back(bus.mem_addr);
                memReads++;
                memCountdown = memLatRandom ? int'($urandom_range(4, 1)) : memLat;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // One clock cycle: drive inputs, check against the model, then update the model after the edge.
    task automatic applyStimulus(input bit v, input logic [1:0] tid, input logic [31:0] addr, input bit rr);
        bit      expReady;
        bit      acc;
        bit      popd;
        expReq_t entry;
        bus.req_valid  = v;
        bus.req_tid    = tid;
        bus.req_addr   = addr;
        bus.resp_ready = rr;
        #2;
        expReady = !modelPending[tid];
        checkOutput("req_ready", 128'(bus.req_ready), 128'(expReady));
        checkOutput("pending", 128'(bus.pending), 128'(modelPending));
        acc  = v && expReady;
        popd = 1'b0;
        if (bus.resp_valid === 1'b1 && rr) begin
            if (expQ.size() == 0) begin
                checkOutput("resp_unexpected", 128'(bus.resp_valid), 128'(1'b0));
            end else begin
                checkOutput("resp_tid", 128'(bus.resp_tid), 128'(expQ[0].tid));
                checkOutput("resp_line", bus.resp_line, expLine(expQ[0].lineAddr));
                popd = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (popd) begin
            modelPending[expQ[0].tid] = 1'b0;
            void'(expQ.pop_front());
        end
        if (acc) begin
            entry.tid      = tid;
            entry.lineAddr = addr[31:4];
            expQ.push_back(entry);
            modelPending[tid] = 1'b1;
        end
        lastAccepted = acc;
    endtask

    task automatic applyReset();
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_tid    = '0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        modelPending = '0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_req_ready"}, 128'(bus.req_ready), 128'(1'b1));
        checkOutput({tag, "_mem_rd_en"}, 128'(bus.mem_rd_en), 128'(1'b0));
        checkOutput({tag, "_mem_addr"}, 128'(bus.mem_addr), 128'(0));
        checkOutput({tag, "_resp_valid"}, 128'(bus.resp_valid), 128'(1'b0));
        checkOutput({tag, "_resp_tid"}, 128'(bus.resp_tid), 128'(0));
        checkOutput({tag, "_resp_line"}, bus.resp_line, 128'(0));
        checkOutput({tag, "_pending"}, 128'(bus.pending), 128'(0));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (expQ.size() > 0 && n < 400) begin
            applyStimulus(1'b0, 2'd0, 32'd0, 1'b1);
            n++;
        end
        checkOutput({tag, "_drained_pending"}, 128'(bus.pending), 128'(0));
    endtask

    initial begin
        int          n;
        int          target;
        int          readsBefore;
        logic [31:0] addr3;

        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_tid    = '0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b0;
        @(posedge clk);
        #1;
        applyReset();
        checkReset("reset");

        // Single refill, L = 1, counting memory data.
        memDataCounting = 1'b1;
        memLat = 1;
        memAddrLog.delete();
        applyStimulus(1'b1, 2'd2, 32'h0000_1238, 1'b1);
        n = 0;
        while (bus.resp_valid !== 1'b1 && n < 40) begin
            applyStimulus(1'b0, 2'd0, 32'd0, 1'b1);
            n++;
        end
        checkOutput("t1_latency", 128'(n + 1), 128'(10));
        checkOutput("t1_tid", 128'(bus.resp_tid), 128'(2));
        checkOutput("t1_line", bus.resp_line, 128'h000000A3_000000A2_000000A1_000000A0);
        applyStimulus(1'b0, 2'd0, 32'd0, 1'b1);
        checkOutput("t1_pending_clear", 128'(bus.pending[2]), 128'(1'b0));
        checkOutput("t1_reads", 128'(memAddrLog.size()), 128'(4));
        for (int k = 0; k < 4 && k < memAddrLog.size(); k++) begin
            checkOutput("t1_mem_addr", 128'(memAddrLog[k]), 128'(32'h1230 + 32'(4 * k)));
        end
        checkOutput("t1_line_retained", bus.resp_line, 128'h000000A3_000000A2_000000A1_000000A0);

        // Four threads back to back.
        memDataCounting = 1'b0;
        applyStimulus(1'b1, 2'd3, $urandom, 1'b1);
        applyStimulus(1'b1, 2'd0, $urandom, 1'b1);
        applyStimulus(1'b1, 2'd1, $urandom, 1'b1);
        applyStimulus(1'b1, 2'd2, $urandom, 1'b1);
        checkOutput("t2_pending_all", 128'(bus.pending), 128'(4'b1111));
        drain("t2");

        // Duplicate TID retried until the cycle after its handshake.
        applyStimulus(1'b1, 2'd1, $urandom, 1'b1);
        n = 0;
        lastAccepted = 1'b0;
        while (!lastAccepted && n < 60) begin
            applyStimulus(1'b1, 2'd1, 32'h0000_5670, 1'b1);
            n++;
        end
        checkOutput("t3_retry_accepted", 128'(bus.pending[1]), 128'(1'b1));
        drain("t3");

        // Backpressure, variable latency, stray memory pulses during RESP.
        memLatRandom = 1'b1;
        applyStimulus(1'b1, 2'd0, $urandom, 1'b0);
        n = 0;
        while (bus.resp_valid !== 1'b1 && n < 60) begin
            applyStimulus(1'b0, 2'd0, 32'd0, 1'b0);
            n++;
        end
        readsBefore = memReads;
        strayEn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checkOutput("t4_hold_valid", 128'(bus.resp_valid), 128'(1'b1));
            checkOutput("t4_hold_tid", 128'(bus.resp_tid), 128'(0));
            checkOutput("t4_hold_line", bus.resp_line, expLine(expQ[0].lineAddr));
            applyStimulus(1'b0, 2'd0, 32'd0, 1'b0);
        end
        strayEn = 1'b0;
        checkOutput("t4_no_extra_reads", 128'(memReads), 128'(readsBefore));
        applyStimulus(1'b0, 2'd0, 32'd0, 1'b1);
        checkOutput("t4_released", 128'(bus.resp_valid), 128'(1'b0));
        memLatRandom = 1'b0;

        // Reset during WAIT of beat 2 with two more requests queued.
        memLat = 4;
        target = memReads + 3;
        applyStimulus(1'b1, 2'd1, $urandom, 1'b1);
        applyStimulus(1'b1, 2'd2, $urandom, 1'b1);
        applyStimulus(1'b1, 2'd3, $urandom, 1'b1);
        n = 0;
        while (memReads < target && n < 80) begin
            applyStimulus(1'b0, 2'd0, 32'd0, 1'b1);
            n++;
        end
        applyReset();
        checkReset("t5");
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b0, 2'd0, 32'd0, 1'b1);
        end
        checkOutput("t5_late_ignored_line", bus.resp_line, 128'(0));
        checkOutput("t5_late_ignored_rd", 128'(bus.mem_rd_en), 128'(1'b0));
        memLat = 1;
        applyStimulus(1'b1, 2'd2, $urandom, 1'b1);
        drain("t5");

        // Pop of TID 0 and accept of TID 3 in the same cycle.
        applyStimulus(1'b1, 2'd0, $urandom, 1'b1);
        n = 0;
        while (bus.resp_valid !== 1'b1 && n < 40) begin
            applyStimulus(1'b0, 2'd0, 32'd0, 1'b1);
            n++;
        end
        addr3 = $urandom;
        applyStimulus(1'b1, 2'd3, addr3, 1'b1);
        checkOutput("t6_pending", 128'(bus.pending), 128'(4'b1000));
        checkOutput("t6_idle_no_rd", 128'(bus.mem_rd_en), 128'(1'b0));
        applyStimulus(1'b0, 2'd0, 32'd0, 1'b1);
        checkOutput("t6_issue_rd", 128'(bus.mem_rd_en), 128'(1'b1));
        checkOutput("t6_issue_addr", 128'(bus.mem_addr), 128'({addr3[31:4], 4'b0000}));
        drain("t6");

        // Randomized traffic.
        memLatRandom = 1'b1;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(1, 0)), 2'($urandom), $urandom,
                          1'($urandom_range(9, 0) < 7));
        end
        drain("rand");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/l1_refill_responder.md
Name: l1_refill_responder

Overview:
- Next-level memory responder for L1 cache line refills in the fine-grained multithreaded core.
- Accepts line-read requests tagged with a thread ID (at most one outstanding per thread), queues them in order, and fetches the four words of each block from a word-wide backing memory.
- Returns the assembled 128-bit line to the L1 with the originating TID.

Parameters:
- WORD_W, 32, word width (= fgmt::WIDTH)
- BEATS, 4, words per line (= fgmt::block_size)
- TID_W, 2, thread ID width (= fgmt::TID_bits)
- NTHREADS, 4, thread count and queue depth (= fgmt::THREAD_POOL_SIZE)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  L1 refill request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_tid  in  TID_W  requesting thread
- req_addr  in  WORD_W  byte address; bits [3:0] ignored
- mem_rd_en  out  1  one-cycle word read strobe
- mem_addr  out  WORD_W  word byte address
- mem_rd_valid  in  1  read data valid, at least 1 cycle after mem_rd_en
- mem_rd_data  in  WORD_W  read data
- resp_valid  out  1  line response valid
- resp_ready  in  1  L1 accepts response
- resp_tid  out  TID_W  thread of the returned line
- resp_line  out  WORD_W*BEATS  word k in bits [32k+31:32k]
- pending  out  NTHREADS  per-thread outstanding mask

Behaviour:
- Clock and reset: single clock domain. rst is synchronous, active-high.
- Reset values:
  - req_ready = 1 (combinational, from pending).
  - mem_rd_en = 0, mem_addr = 0.
  - resp_valid = 0, resp_tid = 0, resp_line = 0.
  - pending = 0. Queue empty, FSM in IDLE, beat counter = 0.
- Request side:
  - req_ready = ~pending[req_tid].
  - On accept: push {tid, addr[31:4]} to the queue; pending[tid] is set from the next cycle.
  - The queue can never overflow: one request per thread, depth NTHREADS.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: queue non-empty -> ISSUE with beat = 0, else stay.
  - ISSUE: mem_rd_en = 1 for exactly this cycle; mem_addr = {head.addr[31:4], beat[1:0], 2'b00}; -> WAIT.
  - WAIT: on mem_rd_valid, capture mem_rd_data into line word[beat].
    - If beat == 3 -> RESP.
    - Else beat += 1 -> ISSUE.
    - Without mem_rd_valid, stay in WAIT; there is no timeout.
  - RESP: resp_valid = 1, resp_tid = head.tid.
    - resp_tid and resp_line stay stable until resp_ready.
    - On resp_valid & resp_ready: pop the queue, clear pending[head.tid], -> IDLE.
- Ordering: responses are strictly in request-acceptance (FIFO) order. Only one memory read is outstanding at a time.
- mem_rd_valid outside WAIT is ignored and does not corrupt the line buffer.
- Latency: with memory latency L (mem_rd_valid exactly L cycles after mem_rd_en) and an idle block, resp_valid rises 2 + 4(L+1) cycles after the accept cycle. For L = 1 this is 10 cycles.
- Simultaneous events:
  - Pop of TID t and a new request from TID t in the same cycle: req_ready is still low for t, so t must retry next cycle.
  - Accept of TID u and pop of a different TID in the same cycle: both occur. Queue occupancy is unchanged.
- resp_line retains the last delivered line after the handshake. It is overwritten beat by beat during the next refill.
- Reset mid-operation (any state): immediate return to reset values. Queued requests are discarded, pending is cleared, and late mem_rd_valid is ignored.

Decomposition:
- Add to package fgmt:
  - typedef refill_req_t {logic [TID_W-1:0] tid; logic [WIDTH-5:0] line_addr;}
  - enum refill_state_t {IDLE, ISSUE, WAIT, RESP}
  - localparam BEAT_BITS = 2
- Sub-module refill_req_fifo:
  - NTHREADS-deep synchronous FIFO of refill_req_t.
  - Ports: push, pop, head, empty, full.
  - Reset: synchronous, active-high.
- Top-level logic: FSM, beat counter, line buffer, pending mask.

Test Plan:
- Single refill: after reset, tid=2, addr=0x0000_1238, memory returns 0xA0+k with L=1, resp_ready=1 -> mem_addr sequence 0x1230/34/38/3C; resp_valid 10 cycles after accept; resp_tid=2; resp_line=0x000000A3_000000A2_000000A1_000000A0; pending[2] cleared after the handshake.
- Four threads back-to-back: tids 3,0,1,2 on consecutive cycles -> all accepted; pending=4'b1111; responses in order 3,0,1,2 with correct lines.
- Duplicate TID: tid=1 requested twice while pending -> req_ready=0 for the second until the cycle after tid 1's response handshake; accepted then, and served.
- Backpressure plus variable latency: resp_ready held 0 for 5 cycles in RESP, L varies 1..4 per beat -> resp_valid, resp_tid and resp_line stable; no extra mem_rd_en; stray mem_rd_valid pulses during RESP ignored.
- Reset mid-WAIT: rst pulsed in beat 2 of a refill with two requests queued -> next cycle all outputs at reset values, pending=0; a late mem_rd_valid is ignored; a new request completes normally.
- Same-cycle pop/accept: tid 0 pops while tid 3 is accepted -> queue holds tid 3 only; its refill starts at IDLE next cycle.
